matrix_result_writer: RTL and testbench
=======================================

MATRIX_RESULT_WRITER -- requirements
Module: matrix_result_writer

Interface
REQ-001 SHALL have parameter CORE_COUNT, default 4, number of accumulator lanes captured per pulse.
REQ-002 SHALL have parameter DATA_W, default 32, width of one accumulator result.
REQ-003 SHALL have parameter ADR_W, default 10, width of result-memory word address.
REQ-004 SHALL have port CLOCK_25  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_capture  input  1  one-cycle pulse: lane accumulators hold a finished dot product.
REQ-007 SHALL have port i_row_adr  input  5  result row for this capture.
REQ-008 SHALL have port i_core_column  input  5  result column of lane 0.
REQ-009 SHALL have port i_size_column  input  8  result matrix column count, static during a job.
REQ-010 SHALL have port i_acc  input  CORE_COUNT*DATA_W  lane results, lane k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port o_wr_en  output  1  write request to result memory.
REQ-012 SHALL have port i_wr_ready  input  1  memory accepts write this cycle.
REQ-013 SHALL have port o_wr_adr  output  ADR_W  write word address.
REQ-014 SHALL have port o_wr_data  output  DATA_W  write data.
REQ-015 SHALL have port o_busy  output  1  any bank holds unwritten lanes.
REQ-016 SHALL have port o_overflow  output  1  sticky: a capture was dropped.

Function
REQ-017 SHALL hold two capture banks (ping-pong); each stores CORE_COUNT results, base address, valid-lane mask.
REQ-018 SHALL on i_capture latch i_acc into the free bank; base = i_row_adr*i_size_column + i_core_column, truncated to ADR_W (wrap modulo 2^ADR_W).
REQ-019 SHALL set lane k valid only if i_core_column + k < i_size_column (9-bit compare); invalid lanes never written.
REQ-020 SHALL use FSM states IDLE (no bank valid) and DRAIN (writing oldest bank); IDLE->DRAIN on capture, DRAIN->IDLE when last valid lane of last valid bank accepted.
REQ-021 SHALL assert o_wr_en the cycle after capture (latency 1) when bank holds a valid lane; o_wr_adr = base + k, o_wr_data = lane k.
REQ-022 SHALL hold o_wr_en, o_wr_adr, o_wr_data stable until o_wr_en & i_wr_ready; then advance to next valid lane, one write per cycle max.
REQ-023 SHALL write lanes in ascending k; banks in capture order.
REQ-024 SHALL, on capture when both banks valid, drop it, set o_overflow until rst; buffered data unaffected.
REQ-025 SHALL accept a capture in the same cycle the final lane of a bank is accepted (bank counts as free).
REQ-026 SHALL treat a capture with zero valid lanes as no-op (no bank used, no write).
REQ-027 SHALL drive o_busy = OR of bank valid flags.

Reset
REQ-028 SHALL on rst clear both banks, lane pointer, FSM to IDLE, o_wr_en=0, o_wr_adr=0, o_wr_data=0, o_busy=0, o_overflow=0.
REQ-029 SHALL on rst mid-DRAIN abandon pending writes; no o_wr_en in the cycle after rst asserted.
REQ-030 SHALL ignore i_capture in cycles with rst high.

Structure
REQ-031 SHALL take CORE_COUNT, DATA_W, ADR_W defaults and FSM state encoding from shared package matrix_pkg.
REQ-032 SHALL instantiate one sub-module result_bank (single capture bank: data, base, mask, valid) twice.

Verification
REQ-033 Size 8, row 2, core 4, acc {40,30,20,10}, ready=1 -> writes (20,10),(21,20),(22,30),(23,40) on 4 consecutive cycles starting capture+1.
REQ-034 Size 6, core 4, row 0 -> only lanes 0,1 written at adr 4,5; o_busy falls after 2nd write.
REQ-035 Ready low 3 cycles on 1st write -> adr/data held stable, no skipped or duplicated write.
REQ-036 Three captures with ready=0 -> first two buffered, o_overflow=1; after ready, 8 writes in capture order.
REQ-037 rst asserted during 2nd of 4 writes -> o_wr_en=0 next cycle, o_busy=0, o_overflow=0.
REQ-038 Row 31, size 255, core 4 -> base 31*255+4=7909 mod 1024=741; writes 741..744.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared defaults, writer FSM encoding and lane-range helper for the matrix result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

  localparam int CORE_COUNT_DEF = 4;
  localparam int DATA_W_DEF     = 32;
  localparam int ADR_W_DEF      = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no bank holds unwritten lanes
    ST_DRAIN = 1'b1   // writing lanes of the oldest bank
  } wr_state_e;

  // A lane carries a real result only if its column lies inside the matrix.
  // The sum is done in 9 bits so core_column + lane never wraps.
  function automatic logic lane_in_range(input logic [4:0] core_column,
                                         input int         lane,
                                         input logic [7:0] size_column);
    logic [8:0] col;
    col = {4'b0000, core_column} + 9'(lane);
    return col < {1'b0, size_column};
  endfunction

endpackage

// File: rtl/result_bank.sv
// One capture bank: lane results, base word address, valid-lane mask and a valid flag.
// Latency: load and release take effect on the next CLOCK_25 edge; load wins over release.
// Backpressure: none; the owner decides when to load and when to release.
// Ports: i_load/i_acc/i_base/i_mask fill the bank, i_release empties it,
//        o_valid/o_acc/o_base/o_mask expose the stored contents.
module result_bank
  import matrix_pkg::*;
#(
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADR_W      = ADR_W_DEF
) (
  input  logic                         CLOCK_25,
  input  logic                         rst,
  input  logic                         i_load,
  input  logic                         i_release,
  input  logic [CORE_COUNT*DATA_W-1:0] i_acc,
  input  logic [ADR_W-1:0]             i_base,
  input  logic [CORE_COUNT-1:0]        i_mask,
  output logic                         o_valid,
  output logic [CORE_COUNT*DATA_W-1:0] o_acc,
  output logic [ADR_W-1:0]             o_base,
  output logic [CORE_COUNT-1:0]        o_mask
);

  logic                         r_valid;
  logic [CORE_COUNT*DATA_W-1:0] r_acc;
  logic [ADR_W-1:0]             r_base;
  logic [CORE_COUNT-1:0]        r_mask;

  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_acc   <= '0;
      r_base  <= '0;
      r_mask  <= '0;
    end else if (i_load) begin
      // A bank released this cycle may be refilled in the same cycle.
      r_valid <= 1'b1;
      r_acc   <= i_acc;
      r_base  <= i_base;
      r_mask  <= i_mask;
    end else if (i_release) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_acc   = r_acc;
  assign o_base  = r_base;
  assign o_mask  = r_mask;

endmodule

// File: rtl/matrix_result_writer.sv
// Captures lane accumulators into ping-pong banks and drains them lane by lane to result memory.
// Latency: first write request appears the cycle after i_capture; one write per accepted cycle.
// Backpressure: o_wr_en/o_wr_adr/o_wr_data hold until i_wr_ready; a capture with both banks full is dropped and flagged.
// Ports: i_capture/i_row_adr/i_core_column/i_size_column/i_acc in; o_wr_en/o_wr_adr/o_wr_data with i_wr_ready out;
//        o_busy = any bank pending, o_overflow = sticky dropped-capture flag.
module matrix_result_writer
  import matrix_pkg::*;
#(
  parameter int CORE_COUNT = CORE_COUNT_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADR_W      = ADR_W_DEF
) (
  input  logic                         CLOCK_25,
  input  logic                         rst,
  input  logic                         i_capture,
  input  logic [4:0]                   i_row_adr,
  input  logic [4:0]                   i_core_column,
  input  logic [7:0]                   i_size_column,
  input  logic [CORE_COUNT*DATA_W-1:0] i_acc,
  output logic                         o_wr_en,
  input  logic                         i_wr_ready,
  output logic [ADR_W-1:0]             o_wr_adr,
  output logic [DATA_W-1:0]            o_wr_data,
  output logic                         o_busy,
  output logic                         o_overflow
);

  localparam int LANE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  wr_state_e                    r_state, w_state_nxt;
  logic                         r_rd_sel;   // bank holding the oldest capture
  logic [LANE_W-1:0]            r_lane;     // lane currently offered to memory
  logic                         r_overflow;

  logic [CORE_COUNT-1:0]        w_cap_mask;
  logic [ADR_W-1:0]             w_cap_base;
  logic                         w_cap;
  logic [1:0]                   w_load, w_rel, w_bank_vld, w_vld_rel;
  logic [CORE_COUNT*DATA_W-1:0] w_bank_acc  [2];
  logic [ADR_W-1:0]             w_bank_base [2];
  logic [CORE_COUNT-1:0]        w_bank_mask [2];
  logic [CORE_COUNT*DATA_W-1:0] w_rd_acc;
  logic [ADR_W-1:0]             w_rd_base;
  logic [CORE_COUNT-1:0]        w_rd_mask;
  logic                         w_more, w_accept, w_done, w_rd_sel_nxt, w_drop;

  // Modular arithmetic in ADR_W bits gives the same result as truncating the full sum.
  assign w_cap_base = ADR_W'(i_row_adr) * ADR_W'(i_size_column) + ADR_W'(i_core_column);

  always_comb begin
    w_cap_mask = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      w_cap_mask[k] = lane_in_range(i_core_column, k, i_size_column);
    end
  end

  // A capture with no in-range lane carries nothing to write.
  assign w_cap = i_capture & (|w_cap_mask);

  for (genvar g = 0; g < 2; g++) begin : g_bank
    result_bank #(
      .CORE_COUNT (CORE_COUNT),
      .DATA_W     (DATA_W),
      .ADR_W      (ADR_W)
    ) u_bank (
      .CLOCK_25  (CLOCK_25),
      .rst       (rst),
      .i_load    (w_load[g]),
      .i_release (w_rel[g]),
      .i_acc     (i_acc),
      .i_base    (w_cap_base),
      .i_mask    (w_cap_mask),
      .o_valid   (w_bank_vld[g]),
      .o_acc     (w_bank_acc[g]),
      .o_base    (w_bank_base[g]),
      .o_mask    (w_bank_mask[g])
    );
  end

  assign w_rd_acc  = w_bank_acc[r_rd_sel];
  assign w_rd_base = w_bank_base[r_rd_sel];
  assign w_rd_mask = w_bank_mask[r_rd_sel];

  // Valid lanes form a prefix of the mask, so the bank ends when lane+1 is invalid.
  always_comb begin
    w_more = 1'b0;
    for (int k = 1; k < CORE_COUNT; k++) begin
      if (int'(r_lane) + 1 == k) w_more = w_rd_mask[k];
    end
  end

  assign w_accept     = (r_state == ST_DRAIN) & i_wr_ready;
  assign w_done       = w_accept & ~w_more;
  assign w_rel        = {w_done & r_rd_sel, w_done & ~r_rd_sel};
  assign w_rd_sel_nxt = w_done ? ~r_rd_sel : r_rd_sel;
  assign w_vld_rel    = w_bank_vld & ~w_rel;

  // Fill the bank that will be read next if it is empty, otherwise the other one;
  // a bank finishing its last lane this cycle already counts as empty.
  always_comb begin
    w_load = 2'b00;
    w_drop = 1'b0;
    if (w_cap) begin
      if (!w_vld_rel[w_rd_sel_nxt])       w_load[w_rd_sel_nxt]  = 1'b1;
      else if (!w_vld_rel[~w_rd_sel_nxt]) w_load[~w_rd_sel_nxt] = 1'b1;
      else                                w_drop                = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_25) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rd_sel   <= 1'b0;
      r_lane     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_sel <= w_rd_sel_nxt;
      if (w_done)        r_lane <= '0;
      else if (w_accept) r_lane <= r_lane + 1'b1;
      if (w_drop)        r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_wr_en     = 1'b0;
    o_wr_adr    = '0;
    o_wr_data   = '0;
    case (r_state)
      ST_IDLE: begin
        if (|w_load) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_wr_en   = 1'b1;
        o_wr_adr  = w_rd_base + ADR_W'(r_lane);
        o_wr_data = w_rd_acc[r_lane*DATA_W +: DATA_W];
        if (w_done && !(|(w_vld_rel | w_load))) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy     = |w_bank_vld;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Directed bench for matrix_result_writer: capture vectors, logged writes vs hand-computed expectations.
// Latency: n/a.
// Backpressure: i_wr_ready is driven low in selected tests to hold writes.
module tb_matrix_result_writer;

  localparam int CC = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic              CLOCK_25 = 1'b0;
  logic              rst;
  logic              i_capture;
  logic [4:0]        i_row_adr;
  logic [4:0]        i_core_column;
  logic [7:0]        i_size_column;
  logic [CC*DW-1:0]  i_acc;
  logic              o_wr_en;
  logic              i_wr_ready;
  logic [AW-1:0]     o_wr_adr;
  logic [DW-1:0]     o_wr_data;
  logic              o_busy;
  logic              o_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int log_adr[$], log_dat[$], log_cyc[$];
  int exp_adr[$], exp_dat[$];

  always #20 CLOCK_25 = ~CLOCK_25;

  always @(posedge CLOCK_25) cyc++;

  matrix_result_writer #(
    .CORE_COUNT (CC),
    .DATA_W     (DW),
    .ADR_W      (AW)
  ) dut (
    .CLOCK_25      (CLOCK_25),
    .rst           (rst),
    .i_capture     (i_capture),
    .i_row_adr     (i_row_adr),
    .i_core_column (i_core_column),
    .i_size_column (i_size_column),
    .i_acc         (i_acc),
    .o_wr_en       (o_wr_en),
    .i_wr_ready    (i_wr_ready),
    .o_wr_adr      (o_wr_adr),
    .o_wr_data     (o_wr_data),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  // Record every write the memory accepts on the coming edge.
  always @(negedge CLOCK_25) begin
    if (rst === 1'b0 && o_wr_en === 1'b1 && i_wr_ready === 1'b1) begin
      log_adr.push_back(int'(o_wr_adr));
      log_dat.push_back(int'(o_wr_data));
      log_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic capture(input logic [4:0] row, input logic [4:0] core, input logic [7:0] size,
                         input int a3, input int a2, input int a1, input int a0);
    i_row_adr     = row;
    i_core_column = core;
    i_size_column = size;
    i_acc         = {a3, a2, a1, a0};
    i_capture     = 1'b1;
    tick();
    i_capture     = 1'b0;
  endtask

  task automatic drain(input string tag);
    i_wr_ready = 1'b1;
    for (int i = 0; i < 40 && o_busy; i++) tick();
    check(tag, o_busy, 1'b0);
  endtask

  task automatic expect_wr(input int adr, input int dat);
    exp_adr.push_back(adr);
    exp_dat.push_back(dat);
  endtask

  task automatic verify_log(input string tag);
    check($sformatf("%s_count", tag), log_adr.size(), exp_adr.size());
    for (int i = 0; i < exp_adr.size(); i++) begin
      if (i < log_adr.size()) begin
        check($sformatf("%s_adr%0d", tag, i), log_adr[i], exp_adr[i]);
        check($sformatf("%s_dat%0d", tag, i), log_dat[i], exp_dat[i]);
      end
    end
    log_adr.delete(); log_dat.delete(); log_cyc.delete();
    exp_adr.delete(); exp_dat.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    i_capture     = 1'b0;
    i_row_adr     = '0;
    i_core_column = '0;
    i_size_column = '0;
    i_acc         = '0;
    i_wr_ready    = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_wr_en", o_wr_en, 0);
    check("rst_adr", o_wr_adr, 0);
    check("rst_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_overflow, 0);

    // Row 2, size 8, core 4: base 20, four lanes on consecutive cycles
    capture(5'd2, 5'd4, 8'd8, 40, 30, 20, 10);
    check("t1_lat_en", o_wr_en, 1);
    check("t1_lat_adr", o_wr_adr, 20);
    check("t1_lat_dat", o_wr_data, 10);
    drain("t1_drain");
    for (int i = 1; i < log_cyc.size(); i++)
      check($sformatf("t1_cyc%0d", i), log_cyc[i] - log_cyc[0], i);
    expect_wr(20, 10); expect_wr(21, 20); expect_wr(22, 30); expect_wr(23, 40);
    verify_log("t1");

    // Size 6, core 4: only lanes 0 and 1 in range
    capture(5'd0, 5'd4, 8'd6, 4, 3, 2, 1);
    check("t2_busy_w1", o_busy, 1);
    tick();
    check("t2_busy_w2", o_busy, 1);
    tick();
    check("t2_busy_end", o_busy, 0);
    check("t2_en_end", o_wr_en, 0);
    expect_wr(4, 1); expect_wr(5, 2);
    verify_log("t2");

    // Memory stalls the first write for 3 cycles
    i_wr_ready = 1'b0;
    capture(5'd0, 5'd0, 8'd8, 104, 103, 102, 101);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_en%0d", i), o_wr_en, 1);
      check($sformatf("t3_hold_adr%0d", i), o_wr_adr, 0);
      check($sformatf("t3_hold_dat%0d", i), o_wr_data, 101);
      if (i < 2) tick();
    end
    drain("t3_drain");
    expect_wr(0, 101); expect_wr(1, 102); expect_wr(2, 103); expect_wr(3, 104);
    verify_log("t3");

    // Three captures while stalled: third is dropped
    i_wr_ready = 1'b0;
    capture(5'd1, 5'd0, 8'd8, 204, 203, 202, 201);
    capture(5'd3, 5'd0, 8'd8, 304, 303, 302, 301);
    check("t4_ovf_before", o_overflow, 0);
    capture(5'd5, 5'd0, 8'd8, 404, 403, 402, 401);
    check("t4_ovf", o_overflow, 1);
    check("t4_busy", o_busy, 1);
    check("t4_head_adr", o_wr_adr, 8);
    drain("t4_drain");
    check("t4_ovf_sticky", o_overflow, 1);
    for (int i = 0; i < 4; i++) expect_wr(8 + i, 201 + i);
    for (int i = 0; i < 4; i++) expect_wr(24 + i, 301 + i);
    verify_log("t4");

    // Reset during the second of four writes; capture under reset ignored
    i_wr_ready = 1'b1;
    capture(5'd0, 5'd0, 8'd8, 504, 503, 502, 501);
    tick();
    check("t5_second_adr", o_wr_adr, 1);
    rst       = 1'b1;
    i_capture = 1'b1;
    tick();
    check("t5_en", o_wr_en, 0);
    check("t5_busy", o_busy, 0);
    check("t5_ovf", o_overflow, 0);
    tick();
    rst       = 1'b0;
    i_capture = 1'b0;
    tick();
    check("t5_busy_after", o_busy, 0);
    check("t5_en_after", o_wr_en, 0);
    expect_wr(0, 501);
    verify_log("t5");

    // Capture lands in the cycle the final lane of the head bank is accepted
    i_wr_ready = 1'b0;
    capture(5'd0, 5'd4, 8'd6, 0, 0, 602, 601);
    capture(5'd1, 5'd4, 8'd6, 0, 0, 612, 611);
    i_wr_ready = 1'b1;
    tick();
    capture(5'd2, 5'd4, 8'd6, 0, 0, 622, 621);
    check("t6_ovf", o_overflow, 0);
    drain("t6_drain");
    expect_wr(4, 601);  expect_wr(5, 602);
    expect_wr(10, 611); expect_wr(11, 612);
    expect_wr(16, 621); expect_wr(17, 622);
    verify_log("t6");

    // Row 31, size 255, core 4: base wraps to 741
    capture(5'd31, 5'd4, 8'd255, 804, 803, 802, 801);
    check("t7_first_adr", o_wr_adr, 741);
    drain("t7_drain");
    for (int i = 0; i < 4; i++) expect_wr(741 + i, 801 + i);
    verify_log("t7");

    // No lane in range: nothing buffered, nothing written
    capture(5'd3, 5'd4, 8'd4, 904, 903, 902, 901);
    check("t8_busy", o_busy, 0);
    check("t8_en", o_wr_en, 0);
    check("t8_ovf", o_overflow, 0);
    tick();
    verify_log("t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
